// File: rtl/cam_query_controller.sv
// cam_query_controller: sequences write/search commands into a CAM, one pin cycle per command,
// and returns search results over a valid/ready port with saturating hit/miss statistics.
module cam_query_controller #(
   parameter int KEY_W   = 8,
   parameter int ADDR_W  = 4,
   parameter int CAM_LAT = 1,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [KEY_W-1:0]  req_key,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              cam_wen,
   output logic              cam_ren,
   output logic [KEY_W-1:0]  cam_din,
   output logic [ADDR_W-1:0] cam_addr,
   input  logic [ADDR_W-1:0] cam_dout,
   input  logic              cam_hit,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_hit,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [KEY_W-1:0]  rsp_key,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam int LW = CAM_LAT > 1 ? $clog2(CAM_LAT) : 1;
   state_t state, state_nx;
   logic op_q;
   logic [KEY_W-1:0] key_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LW-1:0] lat_cnt;
   logic lat_done;
   assign lat_done = lat_cnt == '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      req_ready = state == IDLE;
      rsp_valid = state == RESP;
      cam_wen = state == ISSUE && op_q;
      cam_ren = state == ISSUE && !op_q;
      cam_din = state == ISSUE ? key_q : '0;
      cam_addr = cam_wen ? addr_q : '0;
      case (state)
         IDLE:    state_nx = req_valid ? ISSUE : IDLE;
         ISSUE:   state_nx = op_q ? IDLE : WAIT;
         WAIT:    state_nx = lat_done ? RESP : WAIT;
         RESP:    state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= 1'b0;
         key_q <= '0;
         addr_q <= '0;
         lat_cnt <= '0;
         rsp_hit <= 1'b0;
         rsp_addr <= '0;
         rsp_key <= '0;
         hit_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            op_q <= req_op;
            key_q <= req_key;
            addr_q <= req_addr;
         end
         if (state == ISSUE) lat_cnt <= LW'(CAM_LAT - 1);
         else if (state == WAIT && !lat_done) lat_cnt <= lat_cnt - 1'b1;
         // result capture and statistics share the edge that leaves WAIT
         if (state == WAIT && lat_done) begin
            rsp_hit <= cam_hit;
            rsp_addr <= cam_hit ? cam_dout : '0;
            rsp_key <= key_q;
            if (cam_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (!cam_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cam_query_controller.sv
// tb_cam_query_controller: drives the controller against a behavioural 16x8 CAM (highest index wins)
// and checks every cycle of each command against an array-based reference of CAM contents and counters.
module tb_cam_query_controller;
   logic clk = 1'b0, rst = 1'b1;
   logic req_valid = 1'b0, req_ready, req_op = 1'b0;
   logic [7:0] req_key = '0;
   logic [3:0] req_addr = '0;
   logic cam_wen, cam_ren;
   logic [7:0] cam_din;
   logic [3:0] cam_addr, cam_dout;
   logic cam_hit;
   logic rsp_valid, rsp_ready = 1'b1, rsp_hit;
   logic [3:0] rsp_addr;
   logic [7:0] rsp_key, hit_cnt, miss_cnt;
   int vectors = 0, miscompares = 0;
   logic [7:0] ref_key [16];
   logic ref_v [16];
   int exp_hit = 0, exp_miss = 0;
   logic [7:0] cam_mem [16];
   logic cam_v [16];
   logic mh;
   logic [3:0] ma;

   cam_query_controller #(.KEY_W(8), .ADDR_W(4), .CAM_LAT(1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_key(req_key), .req_addr(req_addr), .cam_wen(cam_wen), .cam_ren(cam_ren),
      .cam_din(cam_din), .cam_addr(cam_addr), .cam_dout(cam_dout), .cam_hit(cam_hit),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
      .rsp_key(rsp_key), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   always #5 clk = ~clk;

   // CAM model: one-cycle search latency, garbage dout on a miss
   initial begin
      for (int i = 0; i < 16; i++) begin cam_mem[i] = '0; cam_v[i] = 1'b0; ref_key[i] = '0; ref_v[i] = 1'b0; end
      cam_hit = 1'b0;
      cam_dout = '0;
   end
   always @(posedge clk) begin
      if (cam_wen) begin cam_mem[cam_addr] <= cam_din; cam_v[cam_addr] <= 1'b1; end
      if (cam_ren) begin
         mh = 1'b0;
         ma = 4'($urandom);
         for (int i = 0; i < 16; i++) if (cam_v[i] && cam_mem[i] == cam_din) begin mh = 1'b1; ma = 4'(i); end
         cam_hit <= mh;
         cam_dout <= ma;
      end
   end

   function automatic void ref_lookup(input logic [7:0] k, output logic h, output logic [3:0] a);
      h = 1'b0;
      a = '0;
      for (int i = 15; i >= 0; i--) if (ref_v[i] && ref_key[i] == k) begin h = 1'b1; a = 4'(i); break; end
   endfunction

   task automatic do_write(input logic [7:0] k, input logic [3:0] a);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready got %b exp 1", req_ready); end
      req_valid = 1'b1; req_op = 1'b1; req_key = k; req_addr = a;
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if ({cam_wen, cam_ren, cam_din, cam_addr, req_ready, rsp_valid} !== {1'b1, 1'b0, k, a, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL wr_issue got wen=%b ren=%b din=%h addr=%h rdy=%b rv=%b exp wen=1 ren=0 din=%h addr=%h rdy=0 rv=0",
                  cam_wen, cam_ren, cam_din, cam_addr, req_ready, rsp_valid, k, a);
      end
      ref_key[a] = k;
      ref_v[a] = 1'b1;
      @(negedge clk);
      vectors++;
      if ({cam_wen, cam_ren, cam_din, cam_addr, req_ready, rsp_valid} !== {1'b0, 1'b0, 8'h0, 4'h0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL wr_done got wen=%b ren=%b din=%h addr=%h rdy=%b rv=%b exp 0 0 00 0 1 0",
                  cam_wen, cam_ren, cam_din, cam_addr, req_ready, rsp_valid);
      end
   endtask

   task automatic do_search(input logic [7:0] k, input int stall);
      logic eh;
      logic [3:0] ea;
      ref_lookup(k, eh, ea);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL sr_ready got %b exp 1", req_ready); end
      req_valid = 1'b1; req_op = 1'b0; req_key = k; req_addr = 4'($urandom);
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if ({cam_ren, cam_wen, cam_din, cam_addr, req_ready, rsp_valid} !== {1'b1, 1'b0, k, 4'h0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL sr_issue got ren=%b wen=%b din=%h addr=%h rdy=%b rv=%b exp ren=1 wen=0 din=%h addr=0 rdy=0 rv=0",
                  cam_ren, cam_wen, cam_din, cam_addr, req_ready, rsp_valid, k);
      end
      rsp_ready = stall == 0;
      @(negedge clk);
      vectors++;
      if ({cam_ren, cam_wen, cam_din, cam_addr, req_ready, rsp_valid} !== 15'h0) begin
         miscompares++;
         $display("FAIL sr_wait got ren=%b wen=%b din=%h addr=%h rdy=%b rv=%b exp all 0",
                  cam_ren, cam_wen, cam_din, cam_addr, req_ready, rsp_valid);
      end
      if (eh) exp_hit = exp_hit < 255 ? exp_hit + 1 : exp_hit;
      else exp_miss = exp_miss < 255 ? exp_miss + 1 : exp_miss;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_hit, rsp_addr, rsp_key, hit_cnt, miss_cnt} !== {1'b1, eh, ea, k, 8'(exp_hit), 8'(exp_miss)}) begin
         miscompares++;
         $display("FAIL sr_rsp key=%h got rv=%b hit=%b addr=%h key=%h hc=%0d mc=%0d exp rv=1 hit=%b addr=%h key=%h hc=%0d mc=%0d",
                  k, rsp_valid, rsp_hit, rsp_addr, rsp_key, hit_cnt, miss_cnt, eh, ea, k, exp_hit, exp_miss);
      end
      repeat (stall) begin
         @(negedge clk);
         vectors++;
         if ({rsp_valid, rsp_hit, rsp_addr, rsp_key, req_ready, cam_ren, cam_wen} !== {1'b1, eh, ea, k, 3'b000}) begin
            miscompares++;
            $display("FAIL sr_stall got rv=%b hit=%b addr=%h key=%h rdy=%b ren=%b wen=%b exp rv=1 hit=%b addr=%h key=%h rdy=0 ren=0 wen=0",
                     rsp_valid, rsp_hit, rsp_addr, rsp_key, req_ready, cam_ren, cam_wen, eh, ea, k);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, req_ready, cam_ren, cam_wen} !== 4'b0100) begin
         miscompares++;
         $display("FAIL sr_done got rv=%b rdy=%b ren=%b wen=%b exp rv=0 rdy=1 ren=0 wen=0", rsp_valid, req_ready, cam_ren, cam_wen);
      end
   endtask

   task automatic check_idle(input string name);
      vectors++;
      if ({req_ready, rsp_valid, cam_wen, cam_ren, cam_din, cam_addr, rsp_hit, rsp_addr, rsp_key, hit_cnt, miss_cnt}
          !== {1'b1, 44'h0}) begin
         miscompares++;
         $display("FAIL %s got rdy=%b rv=%b wen=%b ren=%b din=%h addr=%h hit=%b raddr=%h rkey=%h hc=%0d mc=%0d exp rdy=1 rest 0",
                  name, req_ready, rsp_valid, cam_wen, cam_ren, cam_din, cam_addr, rsp_hit, rsp_addr, rsp_key, hit_cnt, miss_cnt);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      check_idle("reset_held");
      rst = 1'b0;
      @(negedge clk);
      check_idle("reset_released");
      req_valid = 1'b1; req_op = 1'b0; req_key = 8'h04;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("reset_mid_wait");
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_idle("reset_dropped_cmd");
      end
   endtask

   task automatic test_writes;
      do_write(8'd4, 4'd0);
      do_write(8'd8, 4'd7);
      do_write(8'd35, 4'd15);
      do_write(8'd8, 4'd9);
      do_write(8'd8, 4'd5);
   endtask

   task automatic test_hits;
      do_search(8'd4, 0);
      do_search(8'd8, 0);
      do_search(8'd35, 0);
      vectors++;
      if (hit_cnt !== 8'd3) begin miscompares++; $display("FAIL hit_cnt3 got %0d exp 3", hit_cnt); end
   endtask

   task automatic test_misses;
      do_search(8'd87, 0);
      do_search(8'd45, 0);
      vectors++;
      if (miss_cnt !== 8'd2) begin miscompares++; $display("FAIL miss_cnt2 got %0d exp 2", miss_cnt); end
   endtask

   task automatic test_stall;
      do_search(8'd8, 10);
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1) do_write(8'($urandom_range(0, 40)), 4'($urandom));
         else do_search(8'($urandom_range(0, 40)), $urandom_range(0, 3));
      end
   endtask

   task automatic test_saturation;
      int h0;
      h0 = exp_hit;
      for (int n = 0; n < 300; n++) do_search(8'($urandom_range(100, 255)), 0);
      vectors++;
      if ({miss_cnt, hit_cnt} !== {8'hFF, 8'(h0)}) begin
         miscompares++;
         $display("FAIL saturate got mc=%0d hc=%0d exp mc=255 hc=%0d", miss_cnt, hit_cnt, h0);
      end
   endtask

   initial begin
      test_reset;
      test_writes;
      test_hits;
      test_misses;
      test_stall;
      test_random;
      test_saturation;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
